// File: rtl/clk_fbound_host.sv
// clk_fbound_host: sequences an external single-precision bound clipper.
// Loads the low/high bounds into the clipper, feeds it one sample at a time,
// waits for its result with a cycle budget (WAIT_MAX), and presents the clipped
// value on a valid/ready result port.
// Optional feature macro: FBOUND_STATS_EN enables the saturating transfer and
// clipped-result counters. Without it the stat_* outputs are tied to zero.
module clk_fbound_host #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_lo,
  input  logic [31:0] cfg_hi,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_in_bounds,
  output logic [31:0] clp_din,
  output logic        clp_init,
  output logic        clp_start,
  input  logic [31:0] clp_dout,
  input  logic        clp_in_bounds,
  input  logic        clp_finished,
  output logic        busy,
  output logic        err_timeout,
  input  logic        stat_clr,
  output logic [15:0] stat_total,
  output logic [15:0] stat_clipped
);

  localparam int unsigned DATA_W = 32;
  localparam logic [7:0]  WAIT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_START,
    ST_WAIT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   hi_q;
  logic [7:0]          wait_cnt;
  logic [DATA_W-1:0]   clp_din_nxt;
  logic                clp_init_nxt;
  logic                clp_start_nxt;
  logic                cfg_acc;
  logic                s_acc;
  logic                capture;
  logic                timeout;

  // Handshake readiness: config is only taken in IDLE, samples additionally
  // need the result slot free (or draining now) and no competing config.
  assign cfg_ready = (state == ST_IDLE);
  assign s_ready   = (state == ST_IDLE) && (!m_valid || m_ready) && !cfg_valid;
  assign busy      = (state != ST_IDLE);

  // Next-state and next clipper-drive decode.
  always_comb begin
    state_nxt     = state;
    clp_din_nxt   = clp_din;
    clp_init_nxt  = 1'b0;
    clp_start_nxt = 1'b0;
    cfg_acc       = 1'b0;
    s_acc         = 1'b0;
    capture       = 1'b0;
    timeout       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          cfg_acc      = 1'b1;
          state_nxt    = ST_CFG_LO;
          clp_init_nxt = 1'b1;
          clp_din_nxt  = cfg_lo;
        end else if (s_valid && s_ready) begin
          s_acc         = 1'b1;
          state_nxt     = ST_START;
          clp_start_nxt = 1'b1;
          clp_din_nxt   = s_data;
        end
      end
      ST_CFG_LO: begin
        state_nxt   = ST_CFG_HI;
        clp_din_nxt = hi_q;
      end
      ST_CFG_HI: begin
        state_nxt = ST_IDLE;
      end
      ST_START: begin
        // The clipper has not seen the start pulse yet, so any finished
        // level here is stale and deliberately ignored.
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (clp_finished) begin
          capture   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered clipper drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      clp_din   <= '0;
      clp_init  <= 1'b0;
      clp_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      clp_din   <= clp_din_nxt;
      clp_init  <= clp_init_nxt;
      clp_start <= clp_start_nxt;
    end
  end

  // High bound is parked here while the low bound is being loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
    end else if (cfg_acc) begin
      hi_q <= cfg_hi;
    end
  end

  // WAIT cycle counter; restarts from zero every time WAIT is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Result slot: filled from the clipper, held until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_in_bounds <= 1'b0;
    end else if (capture) begin
      m_valid     <= 1'b1;
      m_data      <= clp_dout;
      m_in_bounds <= clp_in_bounds;
    end else if (m_ready) begin
      m_valid     <= 1'b0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (timeout) begin
      err_timeout <= 1'b1;
    end
  end

`ifdef FBOUND_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic m_xfer;
  assign m_xfer = m_valid && m_ready;

  // Saturating counters of delivered results; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_total   <= '0;
      stat_clipped <= '0;
    end else if (stat_clr) begin
      stat_total   <= '0;
      stat_clipped <= '0;
    end else if (m_xfer) begin
      stat_total <= sat_inc(stat_total);
      if (!m_in_bounds) begin
        stat_clipped <= sat_inc(stat_clipped);
      end
    end
  end
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign stat_total      = '0;
  assign stat_clipped    = '0;
`endif

endmodule

// File: tb/tb_clk_fbound_host.sv
// Testbench for clk_fbound_host: directed vector table, hand sequences for
// timeout/reset/stats, and a randomized phase scored against a transaction
// model of the clipper (ordered-key float comparison on the bounds).
module tb_clk_fbound_host;
  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_lo = '0;
  logic [31:0] cfg_hi = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_in_bounds;
  logic [31:0] clp_din;
  logic        clp_init;
  logic        clp_start;
  logic [31:0] clp_dout;
  logic        clp_in_bounds;
  logic        clp_finished;
  logic        busy;
  logic        err_timeout;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_total;
  logic [15:0] stat_clipped;

  always #5 clk = ~clk;

  clk_fbound_host #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_in_bounds(m_in_bounds),
    .clp_din(clp_din), .clp_init(clp_init), .clp_start(clp_start),
    .clp_dout(clp_dout), .clp_in_bounds(clp_in_bounds), .clp_finished(clp_finished),
    .busy(busy), .err_timeout(err_timeout),
    .stat_clr(stat_clr), .stat_total(stat_total), .stat_clipped(stat_clipped)
  );

  int nvec = 0;
  int nmis = 0;
  logic [31:0] ref_lo = '0;
  logic [31:0] ref_hi = '0;

  typedef struct { logic [31:0] d; logic ib; } exp_t;
  exp_t q[$];

  // Monotonic integer key for IEEE single ordering (NaN not used).
  function automatic logic [31:0] fkey(input logic [31:0] b);
    return b[31] ? ~b : (b | 32'h8000_0000);
  endfunction
  function automatic bit clip_low(input logic [31:0] x, input logic [31:0] lo);
    return fkey(x) <= fkey(lo);
  endfunction
  function automatic logic [31:0] clip_val(input logic [31:0] x, lo, hi);
    if (clip_low(x, lo)) return lo;
    if (fkey(x) >= fkey(hi)) return hi;
    return x;
  endfunction
  function automatic logic clip_ib(input logic [31:0] x, lo, hi);
    return !clip_low(x, lo) && (fkey(x) < fkey(hi));
  endfunction
  function automatic logic [31:0] rnd_f();
    logic [31:0] v;
    v = {1'($urandom_range(1)), 8'($urandom_range(135, 120)), 23'($urandom)};
    return v;
  endfunction

  // Behavioural clipper: low bound latched on init, high bound on the beat
  // after; a start produces its result after one cycle for low clips and
  // two otherwise, signalled by a one-cycle finished pulse.
  logic        fin_r = 1'b0;
  logic        fin_glitch = 1'b0;
  logic        stall = 1'b0;
  logic        init_d;
  logic [31:0] b_lo, b_hi;
  int          cdown;
  assign clp_finished = fin_r | fin_glitch;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      b_lo <= '0; b_hi <= '0; init_d <= 1'b0; cdown <= 0;
      fin_r <= 1'b0; clp_dout <= '0; clp_in_bounds <= 1'b0;
    end else begin
      init_d <= clp_init;
      fin_r  <= 1'b0;
      if (clp_init) b_lo <= clp_din;
      if (init_d) b_hi <= clp_din;
      if (cdown > 0) begin
        cdown <= cdown - 1;
        if (cdown == 1) fin_r <= 1'b1;
      end
      if (clp_start && !stall) begin
        clp_dout      <= clip_val(clp_din, b_lo, b_hi);
        clp_in_bounds <= clip_ib(clp_din, b_lo, b_hi);
        cdown         <= clip_low(clp_din, b_lo) ? 1 : 2;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result scoreboard on every delivered transfer.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && m_valid && m_ready) begin
      if (q.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL unexpected_result: got %h expected none", m_data);
      end else begin
        e = q.pop_front();
        chk("sb_m_data", m_data, e.d);
        chk("sb_m_in_bounds", 32'(m_in_bounds), 32'(e.ib));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_in_bounds"}, 32'(m_in_bounds), 0);
    chk({tag, "_clp_din"}, clp_din, 0);
    chk({tag, "_clp_init"}, 32'(clp_init), 0);
    chk({tag, "_clp_start"}, 32'(clp_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
    chk({tag, "_stat_total"}, 32'(stat_total), 0);
    chk({tag, "_stat_clipped"}, 32'(stat_clipped), 0);
  endtask

  task automatic do_cfg(input logic [31:0] lo, input logic [31:0] hi);
    int i;
    for (i = 0; i < 50 && !cfg_ready; i++) tick();
    if (!cfg_ready) begin
      nvec++; nmis++;
      $display("FAIL cfg_ready_wait: got 0 expected 1");
    end
    cfg_valid = 1'b1; cfg_lo = lo; cfg_hi = hi;
    tick();
    cfg_valid = 1'b0; cfg_lo = $urandom; cfg_hi = $urandom;
    chk("cfg_init", 32'(clp_init), 1);
    chk("cfg_start_low", 32'(clp_start), 0);
    chk("cfg_din_lo", clp_din, lo);
    chk("cfg_ready_busy", 32'(cfg_ready), 0);
    tick();
    chk("cfg_init_drop", 32'(clp_init), 0);
    chk("cfg_din_hi", clp_din, hi);
    tick();
    chk("cfg_idle", 32'(busy), 0);
    chk("cfg_ready_back", 32'(cfg_ready), 1);
    ref_lo = lo; ref_hi = hi;
  endtask

  task automatic do_sample(input logic [31:0] x, input logic [31:0] ed, input logic eib,
                           input int lat_exp, input int hold, input bit glitch);
    int lat;
    lat = 0;
    m_ready = 1'b0;
    chk("s_ready_idle", 32'(s_ready), 1);
    s_valid = 1'b1; s_data = x;
    tick();
    s_valid = 1'b0; s_data = $urandom;
    q.push_back('{d: clip_val(x, ref_lo, ref_hi), ib: clip_ib(x, ref_lo, ref_hi)});
    chk("start_pulse", 32'(clp_start), 1);
    chk("start_din", clp_din, x);
    chk("start_init_low", 32'(clp_init), 0);
    if (glitch) fin_glitch = 1'b1;
    for (int n = 1; n <= WAIT_MAX + 4; n++) begin
      tick();
      fin_glitch = 1'b0;
      if (n == 1) chk("start_drop", 32'(clp_start), 0);
      if (m_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(lat_exp));
    chk("din_held", clp_din, x);
    chk("m_data", m_data, ed);
    chk("m_in_bounds", 32'(m_in_bounds), 32'(eib));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(m_valid), 1);
      chk("hold_data", m_data, ed);
      chk("hold_s_ready", 32'(s_ready), 0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("drained", 32'(m_valid), 0);
  endtask

  task automatic rnd_sample();
    logic [31:0] x;
    bit acc;
    x = rnd_f();
    acc = 1'b0;
    s_valid = 1'b1; s_data = x;
    for (int i = 0; i < 100 && !acc; i++) begin
      m_ready = 1'($urandom_range(1));
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (acc) q.push_back('{d: clip_val(x, ref_lo, ref_hi), ib: clip_ib(x, ref_lo, ref_hi)});
    else begin
      nvec++; nmis++;
      $display("FAIL rnd_accept: got 0 expected 1");
    end
  endtask

  typedef struct {
    bit          cfg;
    logic [31:0] a, b, ed;
    logic        eib;
    int          lat, hold;
    bit          glitch;
  } vec_t;
  vec_t tbl[9];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, t;
    tbl[0] = '{0, 32'hBF000000, 0, 32'h00000000, 0, 3, 0, 0};
    tbl[1] = '{0, 32'h3F000000, 0, 32'h00000000, 0, 4, 0, 0};
    tbl[2] = '{1, 32'hBF800000, 32'h3F800000, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 32'h3F000000, 0, 32'h3F000000, 1, 4, 0, 1};
    tbl[4] = '{0, 32'hC0000000, 0, 32'hBF800000, 0, 3, 0, 0};
    tbl[5] = '{0, 32'h40000000, 0, 32'h3F800000, 0, 4, 5, 0};
    tbl[6] = '{0, 32'h3F800000, 0, 32'h3F800000, 0, 4, 0, 0};
    tbl[7] = '{0, 32'hBF800000, 0, 32'hBF800000, 0, 3, 0, 0};
    tbl[8] = '{0, 32'hBE800000, 0, 32'hBE800000, 1, 4, 0, 0};

    // Reset state
    tick(); tick();
    chk_zero_outs("rst");
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    reset = 1'b0;
    tick();
    chk("post_rst_cfg_ready", 32'(cfg_ready), 1);
    chk("post_rst_s_ready", 32'(s_ready), 1);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].cfg) do_cfg(tbl[i].a, tbl[i].b);
      else do_sample(tbl[i].a, tbl[i].ed, tbl[i].eib, tbl[i].lat, tbl[i].hold, tbl[i].glitch);
    end

`ifdef FBOUND_STATS_EN
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    do_sample(32'h3F000000, 32'h3F000000, 1'b1, 4, 0, 0);
    do_sample(32'hC0000000, 32'hBF800000, 1'b0, 3, 0, 0);
    do_sample(32'h40000000, 32'h3F800000, 1'b0, 4, 0, 0);
    chk("stat_total3", 32'(stat_total), 3);
    chk("stat_clipped2", 32'(stat_clipped), 2);
    stat_clr = 1'b1; tick();
    chk("stat_clr_total", 32'(stat_total), 0);
    chk("stat_clr_clipped", 32'(stat_clipped), 0);
    do_sample(32'h40000000, 32'h3F800000, 1'b0, 4, 0, 0);
    stat_clr = 1'b0;
    chk("clr_wins_total", 32'(stat_total), 0);
    chk("clr_wins_clipped", 32'(stat_clipped), 0);
`else
    stat_clr = 1'b1;
    do_sample(32'h40000000, 32'h3F800000, 1'b0, 4, 0, 0);
    stat_clr = 1'b0;
    chk("nostat_total", 32'(stat_total), 0);
    chk("nostat_clipped", 32'(stat_clipped), 0);
`endif

    // Config wins over a simultaneous sample
    cfg_valid = 1'b1; s_valid = 1'b1; s_data = 32'h3F000000;
    cfg_lo = 32'hC0000000; cfg_hi = 32'h40000000;
    #1;
    chk("cfg_win_s_ready", 32'(s_ready), 0);
    tick();
    cfg_valid = 1'b0; s_valid = 1'b0;
    chk("cfg_win_init", 32'(clp_init), 1);
    chk("cfg_win_start", 32'(clp_start), 0);
    tick(); tick();
    ref_lo = 32'hC0000000; ref_hi = 32'h40000000;
    chk("cfg_win_idle", 32'(busy), 0);

    // Timeout: clipper never finishes
    stall = 1'b1; m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'h3F000000;
    tick();
    s_valid = 1'b0;
    for (int n = 1; n <= WAIT_MAX; n++) tick();
    chk("to_not_yet", 32'(err_timeout), 0);
    chk("to_busy", 32'(busy), 1);
    tick();
    chk("to_flag", 32'(err_timeout), 1);
    chk("to_idle", 32'(busy), 0);
    chk("to_no_valid", 32'(m_valid), 0);
    tick();
    chk("to_sticky", 32'(err_timeout), 1);

    // Reset mid-WAIT abandons the sample
    s_valid = 1'b1; s_data = 32'h3F000000;
    tick();
    s_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk_zero_outs("rst_wait");
    tick();
    reset = 1'b0; stall = 1'b0;
    ref_lo = '0; ref_hi = '0;
    for (int n = 0; n < 6; n++) tick();
    chk("rst_wait_no_valid", 32'(m_valid), 0);
    chk("rst_wait_cfg_ready", 32'(cfg_ready), 1);

    // Randomized traffic with backpressure and occasional reconfiguration
    for (int i = 0; i < 150; i++) begin
      if (i == 0 || $urandom_range(9) == 0) begin
        a = rnd_f(); b = rnd_f();
        if (fkey(a) > fkey(b)) begin t = a; a = b; b = t; end
        do_cfg(a, b);
      end else begin
        rnd_sample();
      end
    end
    m_ready = 1'b1;
    for (int n = 0; n < 30; n++) tick();
    chk("sb_queue_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/clk_fbound_host.md
CLK_FBOUND_HOST -- requirements
Module: clk_fbound_host

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of cycles in WAIT before a timeout; legal range 3..255.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cfg_valid/cfg_ready  in/out  1/1  bounds-load handshake.
REQ-005 cfg_lo, cfg_hi  in  32/32  low and high SP-FP bounds.
REQ-006 s_valid/s_ready  in/out  1/1  sample-input handshake; s_data  in  32  SP-FP sample.
REQ-007 m_valid/m_ready  out/in  1/1  result handshake.
REQ-008 m_data  out  32  clipped value; m_in_bounds  out  1  sample was in bounds.
REQ-009 clp_din  out  32; clp_init  out  1; clp_start  out  1  drive the clipper.
REQ-010 clp_dout  in  32; clp_in_bounds  in  1; clp_finished  in  1  clipper returns.
REQ-011 busy  out  1  state not IDLE; err_timeout  out  1  sticky timeout flag.
REQ-012 stat_clr  in  1; stat_total, stat_clipped  out  16/16  statistics (see Configuration).

Function
REQ-013 SHALL implement states IDLE, CFG_LO, CFG_HI, START, WAIT; all clp_* outputs SHALL be registered.
REQ-014 cfg_ready SHALL be 1 only in IDLE; s_ready SHALL be 1 only in IDLE with (!m_valid or m_ready) and cfg_valid=0.
REQ-015 If cfg_valid and s_valid are both 1 in IDLE, configuration SHALL win.
REQ-016 On cfg accept: next state CFG_LO with clp_init=1, clp_din=cfg_lo; cfg_hi SHALL be latched internally.
REQ-017 CFG_LO -> CFG_HI unconditionally: clp_init=0, clp_din=latched hi; CFG_HI -> IDLE unconditionally.
REQ-018 On sample accept: next state START with clp_start=1, clp_din=s_data.
REQ-019 START -> WAIT unconditionally; clp_start=0 in WAIT; clp_finished SHALL be ignored during START.
REQ-020 clp_din SHALL hold the sample value from START until the result is captured.
REQ-021 In WAIT, clp_finished=1 SHALL capture clp_dout into m_data and clp_in_bounds into m_in_bounds, set m_valid, and return to IDLE.
REQ-022 Resulting latency from s accept edge to m_valid: 3 cycles when clipped to low, 4 cycles otherwise.
REQ-023 m_valid SHALL hold with stable m_data until m_ready=1; drain and a new accept in the same cycle SHALL be allowed.
REQ-024 WAIT SHALL count cycles; on reaching WAIT_MAX without clp_finished: set err_timeout, discard the sample, return to IDLE, and produce no m_valid.
REQ-025 err_timeout SHALL clear only on reset.
REQ-026 clp_init and clp_start SHALL never both be 1, and each SHALL be a single-cycle pulse.

Reset
REQ-027 While reset=1, all state SHALL go to zero and state SHALL go to IDLE: m_valid, m_data, m_in_bounds, clp_*, busy, err_timeout, and stats all 0.
REQ-028 Reset mid-CFG or mid-WAIT SHALL abandon the operation with no result emitted.
REQ-029 After reset, cfg_ready SHALL be 1; sending samples before any cfg SHALL be legal (the clipper bounds are then 0/0).

Configuration
REQ-030 Macro FBOUND_STATS_EN SHALL control the statistics counters.
REQ-031 With FBOUND_STATS_EN defined:
- stat_total SHALL increment on each m_valid&&m_ready.
- stat_clipped SHALL increment on the same event when m_in_bounds=0.
- Both counters SHALL saturate at 0xFFFF.
- stat_clr SHALL zero both synchronously and SHALL win over an increment.
REQ-032 Without FBOUND_STATS_EN, the ports SHALL remain, the outputs SHALL be tied 0, stat_clr SHALL be ignored, and no counter flops SHALL exist.

Verification
REQ-033 Config lo=0xBF800000, hi=0x3F800000 -> clp_init high 1 cycle with clp_din=0xBF800000, then clp_din=0x3F800000, then IDLE.
REQ-034 Sample 0x3F000000 -> m_data=0x3F000000, m_in_bounds=1, m_valid 4 cycles after accept.
REQ-035 Sample 0xC0000000 -> m_data=0xBF800000, m_in_bounds=0, latency 3.
REQ-036 Sample 0x40000000, then sample 0x3F800000 -> each gives 0x3F800000, m_in_bounds=0.
- Hold m_ready=0 for 5 cycles on the first result: m_data stable and s_ready=0.
REQ-037 Tie clp_finished=0 after start -> err_timeout=1 after WAIT_MAX WAIT cycles, no m_valid, IDLE; then reset mid-WAIT -> all outputs 0.
REQ-038 With FBOUND_STATS_EN, 3 samples (1 in-bounds) -> stat_total=3, stat_clipped=2; stat_clr -> both 0.
